// File: rtl/piso_serializer.sv
// Parallel-in/serial-out word serializer, MSB first, driving a downstream shift register's d/en pins.
// Latency: first strobe the cycle after the load handshake; done one cycle after the last strobe.
// Backpressure: load_ready is low while a word is in flight. Define SER_PARITY_EN to append an even-parity strobe.
module piso_serializer #(
  parameter int MSB = 16
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           load_valid,
  input  logic [MSB-1:0] load_data,
  output logic           load_ready,
  output logic           d,
  output logic           en,
  output logic           busy,
  output logic           done
);

  localparam int CW = $clog2(MSB) + 1;
  localparam int IW = $clog2(MSB);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

  state_t         state;
  logic [MSB-1:0] hold;
  logic [CW-1:0]  cnt;
  logic [IW-1:0]  bidx;

  assign load_ready = (state == IDLE);

  // cnt strobes already issued; the next bit out is word[MSB-1-cnt]
  assign bidx = IW'(MSB - 1) - cnt[IW-1:0];

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state <= IDLE;
      hold  <= '0;
      cnt   <= '0;
      d     <= 1'b0;
      en    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_valid) begin
            hold  <= load_data;
            d     <= load_data[MSB-1];
            en    <= 1'b1;
            busy  <= 1'b1;
            cnt   <= CW'(1);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt == CW'(MSB)) begin
            cnt <= '0;
`ifdef SER_PARITY_EN
            d     <= ^hold;
            state <= PAR;
`else
            d     <= 1'b0;
            en    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
`endif
          end else begin
            d   <= hold[bidx];
            cnt <= cnt + CW'(1);
          end
        end
`ifdef SER_PARITY_EN
        PAR: begin
          d     <= 1'b0;
          en    <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer (MSB=16) with a behavioural downstream left-shift register on d/en.
module tb_piso_serializer;

`ifdef SER_PARITY_EN
  localparam int NSTB   = 17;
`else
  localparam int NSTB   = 16;
`endif
  localparam int PERIOD = NSTB + 1;

  logic        clk = 1'b0;
  logic        rstn;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic        d;
  logic        en;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  logic [15:0] ds_out = '0;
  logic [15:0] coll;
  logic        pbit;
  int          nstb     = 0;
  int          zero_run = 0;
  int          last_gap = 0;
  int          done_cnt = 0;
  int          cyc      = 0;
  int          hs_cyc   = 0;
  bit          allow_orphan = 1'b0;

  piso_serializer #(.MSB(16)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .d          (d),
    .en         (en),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (en) ds_out <= {ds_out[14:0], d};
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Monitor: sample away from the active edge, pop expectations on each done pulse.
  always @(negedge clk) begin
    if (rstn) begin
      check("rst_en", en, 1'b0);
      check("rst_d", d, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_ready", load_ready, 1'b1);
      nstb = 0;
      coll = '0;
    end else begin
      check("busy_eq_en", busy, en);
      if (!en) begin
        check("d_zero_when_idle", d, 1'b0);
        zero_run++;
      end else begin
        if (nstb == 0) last_gap = zero_run;
        zero_run = 0;
        if (exp_q.size() == 0 && !allow_orphan) flag("unexpected_strobe");
        if (nstb < 16) coll = {coll[14:0], d};
        else pbit = d;
        nstb++;
        if (nstb > NSTB) flag("too_many_strobes");
      end
      if (done) begin
        logic [15:0] e;
        done_cnt++;
        check("done_ready", load_ready, 1'b1);
        if (exp_q.size() == 0) begin
          flag("unexpected_done");
        end else begin
          e = exp_q.pop_front();
          check("word", coll, e);
          check("strobe_count", nstb, NSTB);
`ifdef SER_PARITY_EN
          check("parity", pbit, ^e);
`else
          check("ds_out", ds_out, e);
`endif
        end
        nstb = 0;
        coll = '0;
      end
    end
  end

  task automatic send(input logic [15:0] w, input bit keep_valid, input bit expect_done);
    int n = 0;
    load_valid = 1'b1;
    load_data  = w;
    while (!load_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) flag("handshake_timeout");
    if (expect_done) exp_q.push_back(w);
    @(posedge clk);
    #1;
    hs_cyc = cyc;
    if (!keep_valid) load_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 300) flag("drain_timeout");
  endtask

  initial begin
    int h1;
    int k;
    int dc;
    rstn       = 1'b1;
    load_valid = 1'b1;
    load_data  = 16'hA5C3;
    repeat (2) @(negedge clk);
    #1;
    load_valid = 1'b0;
    rstn       = 1'b0;
    check("post_rst_ready", load_ready, 1'b1);

    // Single word, handshake at the first edge after reset release
    send(16'hA5C3, 1'b0, 1'b1);
    check("first_strobe_en", en, 1'b1);
    check("first_strobe_d", d, 1'b1);
    check("first_ready_low", load_ready, 1'b0);
    drain();

    // Continuous load_valid: second handshake lands on the done edge
    send(16'h0001, 1'b1, 1'b1);
    h1 = hs_cyc;
    send(16'hFFFF, 1'b0, 1'b1);
    check("b2b_period", hs_cyc - h1, PERIOD);
    drain();
    check("b2b_gap", last_gap, 1);
`ifndef SER_PARITY_EN
    check("b2b_ds_out", ds_out, 16'hFFFF);
`endif

    // Input changes while busy must not disturb the latched word
    send(16'hBEEF, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    load_data  = 16'h0000;
    load_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    load_valid = 1'b0;
    drain();

    // Abort after the 5th strobe
    allow_orphan = 1'b1;
    dc = done_cnt;
    send(16'h1234, 1'b0, 1'b0);
    k = 0;
    for (int i = 0; i < 40 && k < 5; i++) begin
      @(negedge clk);
      #1;
      if (en) k++;
    end
    check("abort_strobes_seen", k, 5);
    rstn = 1'b1;
    #1;
    check("abort_en", en, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    rstn = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    check("abort_no_done", done_cnt, dc);
    check("abort_idle_en", en, 1'b0);
    allow_orphan = 1'b0;

    send(16'h00FF, 1'b0, 1'b1);
    drain();

    // Parity-relevant words (odd and even popcount)
    send(16'h0007, 1'b0, 1'b1);
    drain();
    send(16'h0003, 1'b0, 1'b1);
    drain();
    repeat (2) @(negedge clk);
    check("final_scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
